// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with a one-entry skid buffer.
//
// Issues sequential instruction-memory reads, places returned words into the
// IF/ID pipeline register, and absorbs hazard-unit stalls and branch/jump
// redirects without dropping or duplicating instructions.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   if_dr_en       IF/ID enable from hazard unit (0 = stall)
//   flush          redirect request (taken branch/jump)
//   branch_target  redirect address, sampled when flush=1
//   imem_rdata     instruction memory read data, one cycle after a read
//   imem_addr      instruction memory address (current fetch PC)
//   imem_ren       instruction memory read strobe
//   if_id_instr    IF/ID instruction register
//   if_id_pc       IF/ID PC register
//   if_id_valid    IF/ID valid bit
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_dr_en,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_ren,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inflight_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc;
  logic        r_if_id_valid;

  logic        w_ren;
  logic        w_load_mem;
  logic        w_load_hold;
  logic        w_capture;

  // Next state and per-cycle actions. Reset and flush both suppress the
  // fetch; flush takes precedence over the hazard enable in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_ren       = 1'b0;
    w_load_mem  = 1'b0;
    w_load_hold = 1'b0;
    w_capture   = 1'b0;
    if (rst || flush) begin
      w_state_nxt = BOOT;
    end else begin
      unique case (r_state)
        BOOT: begin
          w_ren       = 1'b1;
          w_state_nxt = RUN;
        end
        RUN: begin
          if (if_dr_en) begin
            w_ren      = 1'b1;
            w_load_mem = 1'b1;
          end else begin
            // Returning word would be lost while IF/ID is frozen: park it.
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (if_dr_en) begin
            w_ren       = 1'b1;
            w_load_hold = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_hold_instr  <= NOP_INSTR;
      r_hold_pc     <= RESET_PC;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc    <= RESET_PC;
      r_if_id_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_fetch_pc    <= {branch_target[31:2], 2'b00};
        r_hold_instr  <= NOP_INSTR;
        r_hold_pc     <= RESET_PC;
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
      end else begin
        if (w_ren) begin
          r_inflight_pc <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + 32'd4;  // wraps naturally at 2^32
        end
        if (w_load_mem) begin
          r_if_id_instr <= imem_rdata;
          r_if_id_pc    <= r_inflight_pc;
          r_if_id_valid <= 1'b1;
        end
        if (w_load_hold) begin
          r_if_id_instr <= r_hold_instr;
          r_if_id_pc    <= r_hold_pc;
          r_if_id_valid <= 1'b1;
        end
        if (w_capture) begin
          r_hold_instr <= imem_rdata;
          r_hold_pc    <= r_inflight_pc;
        end
      end
    end
  end

  assign imem_ren    = w_ren;
  assign imem_addr   = r_fetch_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized bench for fetch_stage.
// The reference model treats the stage as a queue of fetched-but-undelivered
// addresses; memory content is 32'h1000_0000 + address, and the memory
// returns junk when no read was accepted the previous cycle.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_dr_en = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .if_dr_en(if_dr_en), .flush(flush),
    .branch_target(branch_target), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .imem_ren(imem_ren),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= mem_word(imem_addr);
    else          imem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: fetched addresses wait in a queue until IF/ID takes them.
  logic        m_known = 1'b0;
  logic        m_boot;
  logic [31:0] m_fpc;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] q[$];

  always @(posedge clk) begin
    logic [31:0] p;
    if (rst) begin
      m_known = 1'b1;
      m_boot  = 1'b1;
      m_fpc   = RST_PC;
      m_instr = NOP;
      m_pc    = RST_PC;
      m_valid = 1'b0;
      q.delete();
    end else if (m_known) begin
      if (flush) begin
        q.delete();
        m_instr = NOP;
        m_valid = 1'b0;
        m_fpc   = {branch_target[31:2], 2'b00};
        m_boot  = 1'b1;
      end else begin
        if (if_dr_en && q.size() > 0) begin
          p       = q.pop_front();
          m_instr = mem_word(p);
          m_pc    = p;
          m_valid = 1'b1;
        end
        if (m_boot || if_dr_en) begin
          q.push_back(m_fpc);
          m_fpc = m_fpc + 32'd4;
        end
        m_boot = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("imem_ren", {31'd0, imem_ren}, {31'd0, !rst && !flush && (m_boot || if_dr_en)});
      chk("imem_addr", imem_addr, m_fpc);
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      chk("if_id_pc", if_id_pc, m_pc);
      chk("if_id_instr", if_id_instr, m_instr);
    end
  end

  // Inputs change 1 time unit after the rising edge; returns at the
  // following falling edge so the caller can inspect that cycle.
  task automatic drive(input logic r, input logic f, input logic e, input logic [31:0] bt);
    @(posedge clk);
    #1;
    rst = r; flush = f; if_dr_en = e; branch_target = bt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (3) drive(1'b1, 1'b0, 1'b1, '0);
    chk("rst_ren", {31'd0, imem_ren}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h0000_0013);
    chk("rst_pc", if_id_pc, 32'h0000_0000);

    // Release and stream
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_ren", {31'd0, imem_ren}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("r1_valid", {31'd0, if_id_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("r2_pc", if_id_pc, 32'h0);
    chk("r2_instr", if_id_instr, 32'h1000_0000);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("r3_pc", if_id_pc, 32'h4);

    // Stall three cycles with pc=8 in IF/ID
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      chk("stall_pc", if_id_pc, 32'h8);
      chk("stall_ren", {31'd0, imem_ren}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("unstall_pc", if_id_pc, 32'h8);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("after_pc12", if_id_pc, 32'hC);
    chk("after_instr12", if_id_instr, 32'h1000_000C);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("after_pc16", if_id_pc, 32'h10);

    // Flush to 0x103
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    chk("flush_ren", {31'd0, imem_ren}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("fl1_valid", {31'd0, if_id_valid}, 32'd0);
    chk("fl1_addr", imem_addr, 32'h100);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("fl2_valid", {31'd0, if_id_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("fl3_pc", if_id_pc, 32'h100);
    chk("fl3_valid", {31'd0, if_id_valid}, 32'd1);
    chk("fl3_instr", if_id_instr, 32'h1000_0100);

    // Flush while in HOLD, stalled through BOOT
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0200);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("hf_boot_ren", {31'd0, imem_ren}, 32'd1);
    chk("hf1_valid", {31'd0, if_id_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("hf2_valid", {31'd0, if_id_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("hf3_valid", {31'd0, if_id_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("hf4_pc", if_id_pc, 32'h200);
    chk("hf4_valid", {31'd0, if_id_valid}, 32'd1);

    // Reset mid-stall
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("mrst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mrst_pc", if_id_pc, 32'h0);
    chk("mrst_instr", if_id_instr, 32'h13);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_ren", {31'd0, imem_ren}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, '0);

    // Address wrap
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("wrap_pc0", if_id_pc, 32'hFFFF_FFF8);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("wrap_pc1", if_id_pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("wrap_pc2", if_id_pc, 32'h0000_0000);
    chk("wrap_instr2", if_id_instr, 32'h1000_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        f;
      logic        e;
      logic [31:0] bt;
      r  = ($urandom_range(0, 99) < 1);
      f  = ($urandom_range(0, 99) < 8);
      e  = ($urandom_range(0, 99) < 70);
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      drive(r, f, e, bt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the instruction presented when IF/ID holds no valid instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port if_dr_en  input  1  IF/ID enable from hazard unit; 0 = stall.
REQ-006 SHALL have port flush  input  1  redirect request (taken branch/jump).
REQ-007 SHALL have port branch_target  input  32  redirect address, sampled when flush=1.
REQ-008 SHALL have port imem_rdata  input  32  instruction memory read data, valid one cycle after an accepted read.
REQ-009 SHALL have port imem_addr  output  32  instruction memory address, equal to fetch_pc.
REQ-010 SHALL have port imem_ren  output  1  instruction memory read strobe.
REQ-011 SHALL have port if_id_instr  output  32  IF/ID instruction register.
REQ-012 SHALL have port if_id_pc  output  32  IF/ID PC register.
REQ-013 SHALL have port if_id_valid  output  1  IF/ID valid bit.

Function
REQ-014 SHALL keep internal registers fetch_pc, inflight_pc, hold_instr, hold_pc and a 3-state FSM: BOOT, RUN, HOLD.
REQ-015 SHALL drive imem_ren = !flush && (state==BOOT || (state!=BOOT && if_dr_en)); imem_addr = fetch_pc every cycle.
REQ-016 SHALL, on every cycle with imem_ren=1, load inflight_pc <= fetch_pc and fetch_pc <= fetch_pc+4, wrapping from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 SHALL in BOOT: leave the IF/ID registers unchanged, issue a fetch, and go to RUN.
REQ-018 SHALL in RUN with if_dr_en=1: load IF/ID <= {imem_rdata, inflight_pc, valid=1}, issue a fetch, and stay in RUN.
REQ-019 SHALL in RUN with if_dr_en=0: hold the IF/ID registers, capture hold_instr <= imem_rdata and hold_pc <= inflight_pc, issue no fetch, and go to HOLD.
REQ-020 SHALL in HOLD with if_dr_en=0: hold all registers, ignore imem_rdata, and stay in HOLD.
REQ-021 SHALL in HOLD with if_dr_en=1: load IF/ID <= {hold_instr, hold_pc, valid=1}, issue a fetch, and go to RUN.
REQ-022 SHALL give flush=1 priority over if_dr_en in every state: IF/ID <= {NOP_INSTR, pc unchanged, valid=0}, fetch_pc <= {branch_target[31:2], 2'b00}, no fetch, hold buffer discarded, next state BOOT.
REQ-023 SHALL, after a flush in cycle t, issue the target fetch in t+1 and present the target instruction in IF/ID with valid=1 from t+3, provided if_dr_en=1 in t+2.
REQ-024 SHALL, in steady RUN with no stall, deliver one instruction per cycle with sequential PCs and no bubbles.
REQ-025 SHALL never drop or duplicate an instruction across any stall length of 1 or more cycles.
REQ-026 SHALL accept if_dr_en=0 during BOOT without loss: the BOOT fetch completes, and the FSM enters HOLD from RUN on the next stalled cycle.

Reset
REQ-027 SHALL on rst=1 set fetch_pc=RESET_PC, inflight_pc=RESET_PC, state=BOOT, if_id_instr=NOP_INSTR, if_id_pc=RESET_PC, if_id_valid=0, hold_instr=NOP_INSTR, hold_pc=RESET_PC.
REQ-028 SHALL let rst override flush and if_dr_en, with any fetch in flight discarded.
REQ-029 SHALL issue the first fetch at RESET_PC in the first cycle after rst deasserts; imem_ren is 0 while rst=1.

Verification
REQ-030 Reset release, if_dr_en=1, memory word at addr A = 32'h1000_0000+A -> IF/ID valid from 2nd cycle after release with pc 0,4,8,... and matching instructions.
REQ-031 Stall for 3 cycles while IF/ID holds pc=8 -> if_id holds pc=8 for 3 cycles, then pc=12, 16 with no gap; imem_ren=0 during the stall.
REQ-032 flush=1 with branch_target=32'h0000_0103 in cycle t -> if_id_valid=0 in t+1 and t+2; imem_addr=32'h0000_0100 in t+1; if_id_pc=32'h100 valid in t+3.
REQ-033 flush and if_dr_en=0 in the same cycle while in HOLD -> flush wins; hold buffer not delivered; next valid pc equals the target.
REQ-034 rst asserted mid-stall in HOLD -> next cycle outputs match REQ-027; restart at RESET_PC.
REQ-035 fetch_pc preloaded via flush to 32'hFFFF_FFF8 -> IF/ID pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
